button_event_gen: RTL and testbench

Input-conditioning stage that sits directly upstream of the person up/down counter. It takes the raw `up` and `down` push-buttons and synchronises each to the board clock. It debounces each with a per-button state machine and emits exactly one single-cycle `inc_pulse` / `dec_pulse` per clean press. These pulses replace the flip-flop/derived-clock path, so the counter runs on `clk` with a pulse enable instead of a generated clock.

---
 rtl/button_event_gen.sv | 172 +++++++++++++++++
 tb/tb_button_event_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
//
// Conditions the raw "person arrived" (up) and "person served" (down) push
// buttons for the person up/down counter. Each button is synchronised to clk,
// debounced by its own four-state machine, and turned into exactly one
// single-cycle enable pulse per clean press. The counter downstream runs on
// clk and uses these pulses as enables. No derived clock is needed.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a level
//                     change (>= 2). The default gives 10 ms at 50 MHz.
//   CNT_W           : debounce counter width.
//
// Ports
//   clk        in  board clock, the only clock in the block
//   reset      in  asynchronous, active-high reset
//   up         in  raw, bouncing, asynchronous arrival button
//   down       in  raw, bouncing, asynchronous served button
//   inc_pulse  out one-cycle pulse per accepted up press
//   dec_pulse  out one-cycle pulse per accepted down press
//   up_level   out debounced level of up
//   down_level out debounced level of down
//   conflict   out one-cycle pulse when both presses are accepted together
// -----------------------------------------------------------------------------
module button_event_gen #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic up,
   input  logic down,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic up_level,
   output logic down_level,
   output logic conflict
);

   // Button index 0 is up, index 1 is down.
   localparam int NBTN = 2;
   localparam int UP   = 0;
   localparam int DN   = 1;

   // cnt runs from 0 to DEBOUNCE_CYCLES-1 and never wraps. The terminal
   // value always fits in CNT_W bits.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      HELD      = 2'd2,
      RELEASING = 2'd3
   } state_t;

   logic [NBTN-1:0] raw;
   logic [NBTN-1:0] s1;
   logic [NBTN-1:0] s2;
   state_t          btn_state [NBTN];
   logic [CNT_W-1:0] cnt      [NBTN];
   logic [NBTN-1:0] level;
   logic [NBTN-1:0] press_ev;

   assign raw = {down, up};

   // ---- Stage: two-flop synchroniser per button --------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // ---- Stage: debounce state machines -----------------------------------
   // ARMING and RELEASING count consecutive samples that disagree with the
   // accepted level. The entry transition already counts as the first
   // sample, so cnt starts at 1 there. Any sample that agrees with the
   // accepted level drops the FSM back and clears the count. A bouncing
   // contact therefore never accumulates credit across bounces.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level <= '0;
         for (int b = 0; b < NBTN; b++) begin
            btn_state[b] <= IDLE;
            cnt[b]       <= '0;
         end
      end else begin
         for (int b = 0; b < NBTN; b++) begin
            case (btn_state[b])
               IDLE: begin
                  if (s2[b]) begin
                     btn_state[b] <= ARMING;
                     cnt[b]       <= CNT_ONE;
                  end
               end

               ARMING: begin
                  if (!s2[b]) begin
                     btn_state[b] <= IDLE;
                     cnt[b]       <= '0;
                  end else if (cnt[b] == CNT_LAST) begin
                     btn_state[b] <= HELD;
                     cnt[b]       <= '0;
                     level[b]     <= 1'b1;
                  end else begin
                     cnt[b] <= cnt[b] + CNT_ONE;
                  end
               end

               HELD: begin
                  if (!s2[b]) begin
                     btn_state[b] <= RELEASING;
                     cnt[b]       <= CNT_ONE;
                  end
               end

               RELEASING: begin
                  if (s2[b]) begin
                     btn_state[b] <= HELD;
                     cnt[b]       <= '0;
                  end else if (cnt[b] == CNT_LAST) begin
                     btn_state[b] <= IDLE;
                     cnt[b]       <= '0;
                     level[b]     <= 1'b0;
                  end else begin
                     cnt[b] <= cnt[b] + CNT_ONE;
                  end
               end

               default: begin
                  btn_state[b] <= IDLE;
                  cnt[b]       <= '0;
               end
            endcase
         end
      end
   end

   // A press event is the ARMING->HELD transition happening on this edge.
   // Decoding it from the current state lets the pulse register fire on the
   // same edge that raises the debounced level.
   always_comb begin
      press_ev = '0;
      for (int b = 0; b < NBTN; b++) begin
         press_ev[b] = (btn_state[b] == ARMING) && s2[b] && (cnt[b] == CNT_LAST);
      end
   end

   // ---- Stage: arbitration and registered pulse outputs ------------------
   // Simultaneous up and down presses cancel: the counter must not move,
   // so only the conflict flag is raised.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_pulse <= 1'b0;
         dec_pulse <= 1'b0;
         conflict  <= 1'b0;
      end else begin
         inc_pulse <= press_ev[UP] & ~press_ev[DN];
         dec_pulse <= press_ev[DN] & ~press_ev[UP];
         conflict  <= press_ev[UP] &  press_ev[DN];
      end
   end

   assign up_level   = level[UP];
   assign down_level = level[DN];

endmodule

// File: tb/tb_button_event_gen.sv
// -----------------------------------------------------------------------------
// tb_button_event_gen
//
// Directed bench for button_event_gen with DEBOUNCE_CYCLES = 4.
//
// The reference model is a behavioural abstraction. Each button's input
// reaches the debouncer two edges late. The accepted level flips after D
// consecutive samples that disagree with it. A 0->1 flip is a press.
// Hand-computed edge numbers pin the scenario-level behaviour.
// -----------------------------------------------------------------------------
module tb_button_event_gen;

   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   logic up;
   logic down;
   logic inc_pulse;
   logic dec_pulse;
   logic up_level;
   logic down_level;
   logic conflict;

   always #5 clk = ~clk;

   button_event_gen #(
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .up        (up),
      .down      (down),
      .inc_pulse (inc_pulse),
      .dec_pulse (dec_pulse),
      .up_level  (up_level),
      .down_level(down_level),
      .conflict  (conflict)
   );

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Edge counter and observed-pulse bookkeeping.
   int cyc      = 0;
   int inc_cnt  = 0;
   int dec_cnt  = 0;
   int cfl_cnt  = 0;
   int last_inc = -1;
   int last_dec = -1;
   int last_cfl = -1;

   // Model state: raw samples from the last two edges, the accepted level,
   // and the current run of disagreeing samples.
   bit m_hist [2][2];
   bit m_lvl  [2];
   int m_run  [2];
   bit m_press[2];
   bit m_raw  [2];
   bit m_seen;
   bit m_inc = 1'b0;
   bit m_dec = 1'b0;
   bit m_cfl = 1'b0;

   initial begin : model_and_compare
      for (int b = 0; b < 2; b++) begin
         m_hist[b][0] = 1'b0; m_hist[b][1] = 1'b0;
         m_lvl[b] = 1'b0; m_run[b] = 0;
      end
      forever begin
         @(posedge clk or posedge reset);
         if (clk) cyc++;
         if (reset) begin
            for (int b = 0; b < 2; b++) begin
               m_hist[b][0] = 1'b0; m_hist[b][1] = 1'b0;
               m_lvl[b] = 1'b0; m_run[b] = 0;
            end
            m_inc = 1'b0; m_dec = 1'b0; m_cfl = 1'b0;
         end else begin
            m_raw[0] = up;
            m_raw[1] = down;
            for (int b = 0; b < 2; b++) begin
               m_press[b] = 1'b0;
               m_seen = m_hist[b][1];
               if (m_seen != m_lvl[b]) begin
                  m_run[b]++;
                  if (m_run[b] == D) begin
                     m_lvl[b]   = ~m_lvl[b];
                     m_run[b]   = 0;
                     m_press[b] = m_lvl[b];
                  end
               end else begin
                  m_run[b] = 0;
               end
               m_hist[b][1] = m_hist[b][0];
               m_hist[b][0] = m_raw[b];
            end
            m_inc = m_press[0] && !m_press[1];
            m_dec = m_press[1] && !m_press[0];
            m_cfl = m_press[0] && m_press[1];
         end
         #1;
         check("inc_pulse",  inc_pulse,  m_inc);
         check("dec_pulse",  dec_pulse,  m_dec);
         check("conflict",   conflict,   m_cfl);
         check("up_level",   up_level,   m_lvl[0]);
         check("down_level", down_level, m_lvl[1]);
         if (inc_pulse === 1'b1) begin inc_cnt++; last_inc = cyc; end
         if (dec_pulse === 1'b1) begin dec_cnt++; last_dec = cyc; end
         if (conflict  === 1'b1) begin cfl_cnt++; last_cfl = cyc; end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   int n;
   int b_inc;
   int b_dec;
   int b_cfl;

   initial begin : stimulus
      reset = 1'b1;
      up    = 1'b0;
      down  = 1'b0;
      tick(3);
      check("reset_outputs",
            int'({inc_pulse, dec_pulse, up_level, down_level, conflict}), 0);
      reset = 1'b0;
      tick(5);

      // Clean press held 50 cycles: one pulse at N+D+1, no repeat.
      b_inc = inc_cnt;
      up = 1'b1; n = cyc + 1;
      tick(50);
      check("clean_inc_count", inc_cnt - b_inc, 1);
      check("clean_inc_edge", last_inc, n + 5);
      check("clean_up_level", up_level, 1);
      up = 1'b0;
      tick(15);
      check("clean_release_level", up_level, 0);

      // Bounce 1,0,1,0,1 then stable: single pulse 5 edges after final rise.
      b_inc = inc_cnt;
      up = 1'b1; tick(1);
      up = 1'b0; tick(1);
      up = 1'b1; tick(1);
      up = 1'b0; tick(1);
      up = 1'b1; n = cyc + 1;
      tick(20);
      check("bounce_inc_count", inc_cnt - b_inc, 1);
      check("bounce_inc_edge", last_inc, n + 5);
      up = 1'b0;
      tick(15);

      // A 3-cycle glitch (D-1 samples) is rejected.
      b_dec = dec_cnt;
      down = 1'b1; tick(3);
      down = 1'b0; tick(12);
      check("glitch_dec_count", dec_cnt - b_dec, 0);
      check("glitch_down_level", down_level, 0);

      // A 4-cycle press (exactly D samples) is accepted.
      b_dec = dec_cnt;
      down = 1'b1; n = cyc + 1;
      tick(4);
      down = 1'b0;
      tick(12);
      check("dpress_dec_count", dec_cnt - b_dec, 1);
      check("dpress_dec_edge", last_dec, n + 5);
      check("dpress_level_after", down_level, 0);

      // Simultaneous press: conflict only, both levels rise.
      b_inc = inc_cnt; b_dec = dec_cnt; b_cfl = cfl_cnt;
      up = 1'b1; down = 1'b1; n = cyc + 1;
      tick(10);
      check("simul_cfl_count", cfl_cnt - b_cfl, 1);
      check("simul_cfl_edge", last_cfl, n + 5);
      check("simul_inc_count", inc_cnt - b_inc, 0);
      check("simul_dec_count", dec_cnt - b_dec, 0);
      check("simul_up_level", up_level, 1);
      check("simul_down_level", down_level, 1);
      up = 1'b0; down = 1'b0;
      tick(15);

      // Down one edge behind up: pulses on consecutive cycles, no conflict.
      b_inc = inc_cnt; b_dec = dec_cnt; b_cfl = cfl_cnt;
      up = 1'b1; n = cyc + 1;
      tick(1);
      down = 1'b1;
      tick(10);
      check("offset_inc_edge", last_inc, n + 5);
      check("offset_dec_edge", last_dec, n + 6);
      check("offset_inc_count", inc_cnt - b_inc, 1);
      check("offset_dec_count", dec_cnt - b_dec, 1);
      check("offset_cfl_count", cfl_cnt - b_cfl, 0);
      up = 1'b0; down = 1'b0;
      tick(15);

      // Reset with down HELD and up ARMING at cnt=2.
      down = 1'b1;
      tick(8);
      check("pre_reset_down_level", down_level, 1);
      b_inc = inc_cnt; b_dec = dec_cnt;
      up = 1'b1;
      tick(4);
      reset = 1'b1; down = 1'b0;
      #1;
      check("async_rst_down_level", down_level, 0);
      check("async_rst_up_level", up_level, 0);
      check("async_rst_inc", inc_pulse, 0);
      tick(2);
      check("rst_no_inc", inc_cnt - b_inc, 0);
      reset = 1'b0; n = cyc + 1;
      tick(12);
      check("post_rst_inc_count", inc_cnt - b_inc, 1);
      check("post_rst_inc_edge", last_inc, n + 5);
      check("post_rst_dec_count", dec_cnt - b_dec, 0);
      up = 1'b0;
      tick(15);

      // Five presses, each held 10 and released 10 cycles.
      b_inc = inc_cnt; b_dec = dec_cnt;
      repeat (5) begin
         up = 1'b1; tick(10);
         up = 1'b0; tick(10);
      end
      tick(5);
      check("repeat_inc_count", inc_cnt - b_inc, 5);
      check("repeat_dec_count", dec_cnt - b_dec, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
